// File: rtl/datactrl_pkg.sv
// Shared constants for the data-side memory controller: bus widths,
// access-width codes and the memory-mapped UART window.
package datactrl_pkg;
  localparam int AddressWidth = 32;
  localparam int IDWidth      = 32;

  // Access widths are one-hot, so the code value equals the byte count.
  localparam logic [2:0] WidthByte = 3'b001;
  localparam logic [2:0] WidthHalf = 3'b010;
  localparam logic [2:0] WidthWord = 3'b100;

  localparam logic [AddressWidth-1:0] IOAddrLo = 32'h0003_0000;
  localparam logic [AddressWidth-1:0] IOAddrHi = 32'h0003_0007;
endpackage

// File: rtl/datactrl.sv
// Data-side memory controller: shares the byte-wide RAM port between fetch,
// loads and committed stores, assembling multi-byte transactions.
module datactrl
  import datactrl_pkg::*;
(
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [AddressWidth-1:0] mem_a,
  output logic                    mem_wr,
  input  logic                    io_buffer_full_in,
  input  logic                    ifetch_datactrl_en_in,
  input  logic [AddressWidth-1:0] ifetch_datactrl_addr_in,
  output logic                    datactrl_ifetch_en_out,
  output logic [IDWidth-1:0]      datactrl_ifetch_data_out,
  input  logic                    lbuffer_datactrl_en_in,
  input  logic [AddressWidth-1:0] lbuffer_datactrl_addr_in,
  input  logic [2:0]              lbuffer_datactrl_width_in,
  input  logic                    lbuffer_datactrl_sgn_in,
  output logic                    datactrl_lbuffer_en_out,
  output logic [IDWidth-1:0]      datactrl_lbuffer_data_out,
  input  logic                    rob_datactrl_en_in,
  input  logic [AddressWidth-1:0] rob_datactrl_addr_in,
  input  logic [2:0]              rob_datactrl_width_in,
  input  logic [IDWidth-1:0]      rob_datactrl_data_in,
  output logic                    datactrl_rob_en_out,
  input  logic                    rob_datactrl_rst_in
);
  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  typedef enum logic {OWN_FETCH, OWN_LOAD} owner_t;

  state_t                  state;
  owner_t                  owner;
  logic [2:0]              cnt;
  logic [2:0]              cnt_next;
  logic [2:0]              width_q;
  logic                    sgn_q;
  logic [AddressWidth-1:0] base_q;
  logic [IDWidth-1:0]      wdata_q;
  logic [IDWidth-1:0]      asm_q;
  logic [IDWidth-1:0]      asm_next;
  logic [1:0]              rd_idx;
  logic                    mem_wr_q;
  logic                    io_store;
  logic                    store_ok;
  logic                    load_ok;
  logic                    fetch_ok;

  function automatic logic [IDWidth-1:0] extend(input logic [IDWidth-1:0] v,
                                                input logic [2:0] w,
                                                input logic sgn);
    logic [IDWidth-1:0] r;
    case (w)
      WidthByte: r = {{(IDWidth-8){sgn & v[7]}}, v[7:0]};
      WidthHalf: r = {{(IDWidth-16){sgn & v[15]}}, v[15:0]};
      default:   r = v;
    endcase
    return r;
  endfunction

  assign cnt_next = cnt + 3'd1;
  // RAM data lags the address by one cycle, so cycle cnt delivers byte cnt-1.
  assign rd_idx   = cnt[1:0] - 2'd1;
  assign io_store = (rob_datactrl_addr_in >= IOAddrLo) && (rob_datactrl_addr_in <= IOAddrHi);

  // A requester's en is ignored while its own done pulse is showing.
  assign store_ok = rob_datactrl_en_in && !datactrl_rob_en_out && !(io_store && io_buffer_full_in);
  assign load_ok  = lbuffer_datactrl_en_in && !datactrl_lbuffer_en_out && !rob_datactrl_rst_in;
  assign fetch_ok = ifetch_datactrl_en_in && !datactrl_ifetch_en_out && !rob_datactrl_rst_in;

  // NOTE: every always_comb output gets a full default first so no latch is inferred.
  always_comb begin
    asm_next = asm_q;
    asm_next[{rd_idx, 3'b000} +: 8] = mem_din;
  end

  assign mem_wr = mem_wr_q & rdy_in;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state                     <= IDLE;
      owner                     <= OWN_FETCH;
      cnt                       <= '0;
      width_q                   <= '0;
      sgn_q                     <= 1'b0;
      base_q                    <= '0;
      wdata_q                   <= '0;
      asm_q                     <= '0;
      mem_a                     <= '0;
      mem_dout                  <= '0;
      mem_wr_q                  <= 1'b0;
      datactrl_ifetch_en_out    <= 1'b0;
      datactrl_ifetch_data_out  <= '0;
      datactrl_lbuffer_en_out   <= 1'b0;
      datactrl_lbuffer_data_out <= '0;
      datactrl_rob_en_out       <= 1'b0;
    end else if (rdy_in) begin
      datactrl_ifetch_en_out  <= 1'b0;
      datactrl_lbuffer_en_out <= 1'b0;
      datactrl_rob_en_out     <= 1'b0;
      mem_wr_q                <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (store_ok) begin
            state    <= WRITE;
            base_q   <= rob_datactrl_addr_in;
            width_q  <= rob_datactrl_width_in;
            wdata_q  <= rob_datactrl_data_in;
            mem_a    <= rob_datactrl_addr_in;
            mem_dout <= rob_datactrl_data_in[7:0];
            mem_wr_q <= 1'b1;
          end else if (load_ok) begin
            state   <= READ;
            owner   <= OWN_LOAD;
            base_q  <= lbuffer_datactrl_addr_in;
            width_q <= lbuffer_datactrl_width_in;
            sgn_q   <= lbuffer_datactrl_sgn_in;
            mem_a   <= lbuffer_datactrl_addr_in;
          end else if (fetch_ok) begin
            state   <= READ;
            owner   <= OWN_FETCH;
            base_q  <= ifetch_datactrl_addr_in;
            width_q <= WidthWord;
            sgn_q   <= 1'b0;
            mem_a   <= ifetch_datactrl_addr_in;
          end
        end
        READ: begin
          if (rob_datactrl_rst_in) begin
            state <= IDLE;
          end else begin
            cnt <= cnt_next;
            if (cnt_next < width_q) mem_a <= base_q + AddressWidth'(cnt_next);
            if (cnt != 3'd0) asm_q <= asm_next;
            if (cnt == width_q) begin
              state <= IDLE;
              if (owner == OWN_LOAD) begin
                datactrl_lbuffer_en_out   <= 1'b1;
                datactrl_lbuffer_data_out <= extend(asm_next, width_q, sgn_q);
              end else begin
                datactrl_ifetch_en_out   <= 1'b1;
                datactrl_ifetch_data_out <= asm_next;
              end
            end
          end
        end
        WRITE: begin
          cnt <= cnt_next;
          if (cnt_next < width_q) begin
            mem_a    <= base_q + AddressWidth'(cnt_next);
            mem_dout <= wdata_q[{cnt_next[1:0], 3'b000} +: 8];
            mem_wr_q <= 1'b1;
          end else begin
            state               <= IDLE;
            datactrl_rob_en_out <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_datactrl.sv
// Self-checking bench for datactrl: a byte RAM model plus scoreboard queues
// of expected done pulses and RAM writes, checked every cycle by step().
module tb_datactrl;
  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full_in = 1'b0;
  logic        ifetch_datactrl_en_in = 1'b0;
  logic [31:0] ifetch_datactrl_addr_in = '0;
  logic        datactrl_ifetch_en_out;
  logic [31:0] datactrl_ifetch_data_out;
  logic        lbuffer_datactrl_en_in = 1'b0;
  logic [31:0] lbuffer_datactrl_addr_in = '0;
  logic [2:0]  lbuffer_datactrl_width_in = '0;
  logic        lbuffer_datactrl_sgn_in = 1'b0;
  logic        datactrl_lbuffer_en_out;
  logic [31:0] datactrl_lbuffer_data_out;
  logic        rob_datactrl_en_in = 1'b0;
  logic [31:0] rob_datactrl_addr_in = '0;
  logic [2:0]  rob_datactrl_width_in = '0;
  logic [31:0] rob_datactrl_data_in = '0;
  logic        datactrl_rob_en_out;
  logic        rob_datactrl_rst_in = 1'b0;

  logic        pre_we = 1'b0;
  logic [17:0] pre_a = '0;
  logic [7:0]  pre_d = '0;
  logic [7:0]  ram [0:262143];

  logic [31:0] exp_lb[$];
  logic [31:0] exp_if[$];
  wr_t         exp_wr[$];
  int          exp_rob = 0;
  int          checks = 0;
  int          fails = 0;
  int          cyc = 0;
  int          lb_done_cyc = 0, if_done_cyc = 0, rob_done_cyc = 0, wr_cyc = 0;
  int          lb_done_cnt = 0, if_done_cnt = 0, rob_done_cnt = 0;

  datactrl dut (
    .clk_in                    (clk_in),
    .rst_in                    (rst_in),
    .rdy_in                    (rdy_in),
    .mem_din                   (mem_din),
    .mem_dout                  (mem_dout),
    .mem_a                     (mem_a),
    .mem_wr                    (mem_wr),
    .io_buffer_full_in         (io_buffer_full_in),
    .ifetch_datactrl_en_in     (ifetch_datactrl_en_in),
    .ifetch_datactrl_addr_in   (ifetch_datactrl_addr_in),
    .datactrl_ifetch_en_out    (datactrl_ifetch_en_out),
    .datactrl_ifetch_data_out  (datactrl_ifetch_data_out),
    .lbuffer_datactrl_en_in    (lbuffer_datactrl_en_in),
    .lbuffer_datactrl_addr_in  (lbuffer_datactrl_addr_in),
    .lbuffer_datactrl_width_in (lbuffer_datactrl_width_in),
    .lbuffer_datactrl_sgn_in   (lbuffer_datactrl_sgn_in),
    .datactrl_lbuffer_en_out   (datactrl_lbuffer_en_out),
    .datactrl_lbuffer_data_out (datactrl_lbuffer_data_out),
    .rob_datactrl_en_in        (rob_datactrl_en_in),
    .rob_datactrl_addr_in      (rob_datactrl_addr_in),
    .rob_datactrl_width_in     (rob_datactrl_width_in),
    .rob_datactrl_data_in      (rob_datactrl_data_in),
    .datactrl_rob_en_out       (datactrl_rob_en_out),
    .rob_datactrl_rst_in       (rob_datactrl_rst_in)
  );

  always #5 clk_in = ~clk_in;

  // Byte RAM with one-cycle read latency; holds mem_din while rdy_in is low.
  always @(posedge clk_in) begin
    if (pre_we) begin
      ram[pre_a] <= pre_d;
    end else if (rdy_in) begin
      mem_din <= ram[mem_a[17:0]];
      if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
    end
  end

  // Advance one cycle and score every done pulse and RAM write it shows.
  task automatic step();
    logic [31:0] e;
    wr_t         w;
    @(negedge clk_in);
    cyc++;
    if (datactrl_lbuffer_en_out === 1'b1) begin
      checks++;
      lb_done_cyc = cyc;
      lb_done_cnt++;
      lbuffer_datactrl_en_in = 1'b0;
      if (exp_lb.size() == 0) begin
        fails++;
        $display("FAIL lbuffer_done: unexpected pulse data=%h at cycle %0d, required no pulse", datactrl_lbuffer_data_out, cyc);
      end else begin
        e = exp_lb.pop_front();
        if (datactrl_lbuffer_data_out !== e) begin
          fails++;
          $display("FAIL lbuffer_data: got %h, required %h", datactrl_lbuffer_data_out, e);
        end
      end
    end
    if (datactrl_ifetch_en_out === 1'b1) begin
      checks++;
      if_done_cyc = cyc;
      if_done_cnt++;
      ifetch_datactrl_en_in = 1'b0;
      if (exp_if.size() == 0) begin
        fails++;
        $display("FAIL ifetch_done: unexpected pulse data=%h at cycle %0d, required no pulse", datactrl_ifetch_data_out, cyc);
      end else begin
        e = exp_if.pop_front();
        if (datactrl_ifetch_data_out !== e) begin
          fails++;
          $display("FAIL ifetch_data: got %h, required %h", datactrl_ifetch_data_out, e);
        end
      end
    end
    if (datactrl_rob_en_out === 1'b1) begin
      checks++;
      rob_done_cyc = cyc;
      rob_done_cnt++;
      rob_datactrl_en_in = 1'b0;
      if (exp_rob == 0) begin
        fails++;
        $display("FAIL rob_done: unexpected pulse at cycle %0d, required no pulse", cyc);
      end else begin
        exp_rob--;
      end
    end
    if (mem_wr === 1'b1) begin
      checks++;
      wr_cyc = cyc;
      if (exp_wr.size() == 0) begin
        fails++;
        $display("FAIL mem_write: unexpected write %h to %h, required no write", mem_dout, mem_a);
      end else begin
        w = exp_wr.pop_front();
        if ({mem_a, mem_dout} !== {w.addr, w.data}) begin
          fails++;
          $display("FAIL mem_write: got %h@%h, required %h@%h", mem_dout, mem_a, w.data, w.addr);
        end
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_lb.size() != 0 || exp_if.size() != 0 || exp_wr.size() != 0 || exp_rob != 0) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (exp_lb.size() != 0 || exp_if.size() != 0 || exp_wr.size() != 0 || exp_rob != 0) begin
      fails++;
      $display("FAIL timeout: pending lb=%0d if=%0d wr=%0d rob=%0d, required all 0",
               exp_lb.size(), exp_if.size(), exp_wr.size(), exp_rob);
      exp_lb.delete();
      exp_if.delete();
      exp_wr.delete();
      exp_rob = 0;
    end
    repeat (4) step();
  endtask

  task automatic write_ram(input logic [17:0] a, input logic [7:0] d);
    pre_a  = a;
    pre_d  = d;
    pre_we = 1'b1;
    step();
    pre_we = 1'b0;
  endtask

  task automatic start_load(input logic [31:0] a, input logic [2:0] w, input logic s, input logic [31:0] e);
    lbuffer_datactrl_addr_in  = a;
    lbuffer_datactrl_width_in = w;
    lbuffer_datactrl_sgn_in   = s;
    lbuffer_datactrl_en_in    = 1'b1;
    exp_lb.push_back(e);
  endtask

  task automatic start_store(input logic [31:0] a, input logic [2:0] w, input logic [31:0] d, input logic expect_writes);
    rob_datactrl_addr_in  = a;
    rob_datactrl_width_in = w;
    rob_datactrl_data_in  = d;
    rob_datactrl_en_in    = 1'b1;
    if (expect_writes) begin
      for (int k = 0; k < int'(w); k++) exp_wr.push_back('{addr: a + k, data: d[8*k +: 8]});
      exp_rob++;
    end
  endtask

  task automatic test_reset();
    write_ram(18'h01000, 8'h78);
    write_ram(18'h01001, 8'h56);
    write_ram(18'h01002, 8'h34);
    write_ram(18'h01003, 8'h12);
    write_ram(18'h01004, 8'h80);
    write_ram(18'h01006, 8'h00);
    write_ram(18'h01007, 8'h80);
    checks++;
    if (mem_a !== 32'h0 || mem_dout !== 8'h0 || mem_wr !== 1'b0) begin
      fails++;
      $display("FAIL reset_mem: got a=%h dout=%h wr=%b, required 0 0 0", mem_a, mem_dout, mem_wr);
    end
    checks++;
    if ({datactrl_ifetch_en_out, datactrl_lbuffer_en_out, datactrl_rob_en_out} !== 3'b000) begin
      fails++;
      $display("FAIL reset_done: got %b%b%b, required 000", datactrl_ifetch_en_out, datactrl_lbuffer_en_out, datactrl_rob_en_out);
    end
    checks++;
    if (datactrl_ifetch_data_out !== 32'h0 || datactrl_lbuffer_data_out !== 32'h0) begin
      fails++;
      $display("FAIL reset_data: got %h %h, required 0 0", datactrl_ifetch_data_out, datactrl_lbuffer_data_out);
    end
    rst_in = 1'b0;
    step();
  endtask

  task automatic test_word_load();
    int c = cyc;
    start_load(32'h1000, 3'b100, 1'b0, 32'h1234_5678);
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (mem_a !== 32'h1000 + k) begin
        fails++;
        $display("FAIL lw_addr%0d: got %h, required %h", k, mem_a, 32'h1000 + k);
      end
    end
    wait_idle(20);
    checks++;
    if (lb_done_cyc - c != 6) begin
      fails++;
      $display("FAIL lw_latency: got %0d, required 6", lb_done_cyc - c);
    end
  endtask

  task automatic test_extension();
    logic [2:0]  w_t [4] = '{3'b001, 3'b001, 3'b010, 3'b010};
    logic        s_t [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] a_t [4] = '{32'h1004, 32'h1004, 32'h1006, 32'h1006};
    logic [31:0] e_t [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8000, 32'h0000_8000};
    for (int i = 0; i < 4; i++) begin
      int c = cyc;
      start_load(a_t[i], w_t[i], s_t[i], e_t[i]);
      wait_idle(20);
      checks++;
      if (lb_done_cyc - c != int'(w_t[i]) + 2) begin
        fails++;
        $display("FAIL ext_latency%0d: got %0d, required %0d", i, lb_done_cyc - c, int'(w_t[i]) + 2);
      end
    end
  endtask

  task automatic test_fetch();
    int c = cyc;
    ifetch_datactrl_addr_in = 32'h1000;
    ifetch_datactrl_en_in   = 1'b1;
    exp_if.push_back(32'h1234_5678);
    wait_idle(20);
    checks++;
    if (if_done_cyc - c != 6) begin
      fails++;
      $display("FAIL fetch_latency: got %0d, required 6", if_done_cyc - c);
    end
  endtask

  task automatic test_arbitration();
    int c = cyc;
    int l0 = lb_done_cnt, f0 = if_done_cnt, r0 = rob_done_cnt;
    start_store(32'h2000, 3'b100, 32'hDEAD_BEEF, 1'b1);
    start_load(32'h1004, 3'b001, 1'b1, 32'hFFFF_FF80);
    ifetch_datactrl_addr_in = 32'h1000;
    ifetch_datactrl_en_in   = 1'b1;
    exp_if.push_back(32'h1234_5678);
    wait_idle(40);
    checks++;
    if (rob_done_cyc - c != 5 || lb_done_cyc - c != 8 || if_done_cyc - c != 14) begin
      fails++;
      $display("FAIL arb_order: got store/load/fetch at %0d/%0d/%0d, required 5/8/14",
               rob_done_cyc - c, lb_done_cyc - c, if_done_cyc - c);
    end
    checks++;
    if (lb_done_cnt - l0 != 1 || if_done_cnt - f0 != 1 || rob_done_cnt - r0 != 1) begin
      fails++;
      $display("FAIL arb_once: got %0d/%0d/%0d pulses, required 1/1/1", rob_done_cnt - r0, lb_done_cnt - l0, if_done_cnt - f0);
    end
  endtask

  task automatic test_flush();
    int c = cyc;
    int l0 = lb_done_cnt;
    lbuffer_datactrl_addr_in  = 32'h1000;
    lbuffer_datactrl_width_in = 3'b100;
    lbuffer_datactrl_sgn_in   = 1'b0;
    lbuffer_datactrl_en_in    = 1'b1;
    repeat (4) step();
    rob_datactrl_rst_in = 1'b1;
    step();
    rob_datactrl_rst_in    = 1'b0;
    lbuffer_datactrl_en_in = 1'b0;
    start_store(32'h2100, 3'b001, 32'h0000_005A, 1'b1);
    wait_idle(20);
    checks++;
    if (wr_cyc - c != 6 || lb_done_cnt != l0) begin
      fails++;
      $display("FAIL flush_read: got write at %0d, load pulses %0d, required 6 and 0", wr_cyc - c, lb_done_cnt - l0);
    end
    c = cyc;
    start_store(32'h2200, 3'b100, 32'hCAFE_F00D, 1'b1);
    repeat (2) step();
    rob_datactrl_rst_in = 1'b1;
    step();
    rob_datactrl_rst_in = 1'b0;
    wait_idle(20);
    checks++;
    if (rob_done_cyc - c != 5) begin
      fails++;
      $display("FAIL flush_write: got done at %0d, required 5", rob_done_cyc - c);
    end
  endtask

  task automatic test_io_backpressure();
    int n = 0;
    io_buffer_full_in = 1'b1;
    start_store(32'h0003_0000, 3'b001, 32'h0000_0041, 1'b0);
    start_load(32'h1004, 3'b001, 1'b0, 32'h0000_0080);
    while (exp_lb.size() != 0 && n < 20) begin
      step();
      n++;
    end
    repeat (5) step();
    checks++;
    if (exp_lb.size() != 0 || rob_datactrl_en_in !== 1'b1) begin
      fails++;
      $display("FAIL io_hold: got pending loads %0d store_en %b, required 0 and 1", exp_lb.size(), rob_datactrl_en_in);
    end
    io_buffer_full_in = 1'b0;
    exp_wr.push_back('{addr: 32'h0003_0000, data: 8'h41});
    exp_rob++;
    wait_idle(20);
    checks++;
    if (ram[18'h30000] !== 8'h41) begin
      fails++;
      $display("FAIL io_write: got %h at 0x30000, required 41", ram[18'h30000]);
    end
  endtask

  task automatic test_stall_and_reset();
    int c = cyc;
    int r0;
    start_load(32'h1000, 3'b100, 1'b0, 32'h1234_5678);
    repeat (2) step();
    rdy_in = 1'b0;
    repeat (3) step();
    rdy_in = 1'b1;
    wait_idle(30);
    checks++;
    if (lb_done_cyc - c != 9) begin
      fails++;
      $display("FAIL stall_latency: got %0d, required 9", lb_done_cyc - c);
    end
    r0 = rob_done_cnt;
    rob_datactrl_addr_in  = 32'h2300;
    rob_datactrl_width_in = 3'b100;
    rob_datactrl_data_in  = 32'h1122_3344;
    rob_datactrl_en_in    = 1'b1;
    exp_wr.push_back('{addr: 32'h2300, data: 8'h44});
    exp_wr.push_back('{addr: 32'h2301, data: 8'h33});
    repeat (2) step();
    rst_in             = 1'b1;
    rob_datactrl_en_in = 1'b0;
    step();
    checks++;
    if ({mem_a, mem_dout, mem_wr, datactrl_rob_en_out, datactrl_lbuffer_en_out, datactrl_ifetch_en_out} !== 44'h0 ||
        datactrl_lbuffer_data_out !== 32'h0 || datactrl_ifetch_data_out !== 32'h0) begin
      fails++;
      $display("FAIL reset_mid_store: got a=%h dout=%h wr=%b rob=%b ldata=%h, required all 0",
               mem_a, mem_dout, mem_wr, datactrl_rob_en_out, datactrl_lbuffer_data_out);
    end
    rst_in = 1'b0;
    wait_idle(10);
    repeat (6) step();
    checks++;
    if (rob_done_cnt != r0) begin
      fails++;
      $display("FAIL reset_no_done: got %0d store pulses, required 0", rob_done_cnt - r0);
    end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_extension();
    test_fetch();
    test_arbitration();
    test_flush();
    test_io_backpressure();
    test_stall_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
